control_unit: RTL

Hardwired Moore controller that drives the datapath's control strobes (PCout, MARin, Read, MDRin, GRA/GRB/GRC, Rin/Rout, Zin, operation, and so on). It replaces the hand-sequenced stimulus used to exercise the datapath today. It sits beside `datapath`: it takes IR and the CON flip-flop output, steps one state per clock through fetch and the execute sequence of each supported opcode, and is the issuing end of the control-strobe interface the datapath consumes.

---
 rtl/cpu_defs_pkg.sv | 66 ++++++
 rtl/control_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, ALU operation codes and the controller
// state encoding, plus small helpers that group opcodes by instruction class.
package cpu_defs_pkg;

   localparam int OPCODE_W = 5;

   // Instruction opcodes, as found in IR[31:27]
   localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
   localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10011;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

   // ALU operation codes driven on the operation bus
   localparam logic [OPCODE_W-1:0] ALU_ADD = 5'b00011;
   localparam logic [OPCODE_W-1:0] ALU_AND = 5'b00101;
   localparam logic [OPCODE_W-1:0] ALU_OR  = 5'b00110;

   // Controller states; T3..T7 are shared by all opcodes
   typedef enum logic [3:0] {
      RESET_S = 4'd0,
      T0      = 4'd1,
      T1      = 4'd2,
      T2      = 4'd3,
      T3      = 4'd4,
      T4      = 4'd5,
      T5      = 4'd6,
      T6      = 4'd7,
      T7      = 4'd8,
      HALT_S  = 4'd9
   } state_t;

   // Memory-address class: effective address computed as base + constant
   function automatic logic is_mem_class(input logic [OPCODE_W-1:0] op);
      return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
   endfunction

   // Register-register ALU class: the opcode doubles as the ALU operation
   function automatic logic is_rr_class(input logic [OPCODE_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   // Register-immediate ALU class
   function automatic logic is_imm_class(input logic [OPCODE_W-1:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   // ALU operation used by each immediate opcode
   function automatic logic [OPCODE_W-1:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
      logic [OPCODE_W-1:0] res;
      res = ALU_ADD;
      if (op == OP_ANDI) res = ALU_AND;
      if (op == OP_ORI)  res = ALU_OR;
      return res;
   endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore controller for the datapath. Steps one state per clock
// through fetch (T0..T2) and the opcode-specific execute states (T3..T7),
// decoding the control strobes from the registered state and IR opcode.
module control_unit #(
   parameter int OPW = 5
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic           Stop,
   input  logic [31:0]    IR,
   input  logic           CON_FF,
   output logic           PCout,
   output logic           Zlowout,
   output logic           ZHighout,
   output logic           MDRout,
   output logic           HIout,
   output logic           LOout,
   output logic           Cout,
   output logic           InPortout,
   output logic           BAout,
   output logic           Rout,
   output logic           PCin,
   output logic           MARin,
   output logic           MDRin,
   output logic           IRin,
   output logic           Yin,
   output logic           Zin,
   output logic           Rin,
   output logic           CONin,
   output logic           GRA,
   output logic           GRB,
   output logic           GRC,
   output logic           IncPC,
   output logic           Read,
   output logic           Write,
   output logic [OPW-1:0] operation,
   output logic           Run
);

   import cpu_defs_pkg::*;

   state_t              state;
   state_t              next_state;
   logic [OPCODE_W-1:0] opcode;
   logic                unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   // State register; Reset wins at any edge so no partial sequence survives
   always_ff @(posedge Clock) begin
      if (Reset) state <= RESET_S;
      else       state <= next_state;
   end

   // Next-state selection; execute length depends on the opcode class
   always_comb begin
      next_state = T0;
      case (state)
         RESET_S: next_state = T0;
         T0:      next_state = Stop ? HALT_S : T1;
         T1:      next_state = T2;
         T2:      next_state = T3;
         T3: begin
            if (opcode == OP_HALT)
               next_state = HALT_S;
            else if (is_mem_class(opcode) || is_rr_class(opcode) ||
                     is_imm_class(opcode) || (opcode == OP_BR))
               next_state = T4;
            else
               next_state = T0;
         end
         T4:      next_state = T5;
         T5: begin
            if ((opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_BR))
               next_state = T6;
            else
               next_state = T0;
         end
         T6: begin
            if ((opcode == OP_LD) || (opcode == OP_ST))
               next_state = T7;
            else
               next_state = T0;
         end
         T7:      next_state = T0;
         HALT_S:  next_state = HALT_S;
         default: next_state = RESET_S;
      endcase
   end

   // Strobe decode of the registered state; T0 is muted by Stop and T6 of br by CON_FF
   always_comb begin
      PCout     = 1'b0;
      Zlowout   = 1'b0;
      ZHighout  = 1'b0;
      MDRout    = 1'b0;
      HIout     = 1'b0;
      LOout     = 1'b0;
      Cout      = 1'b0;
      InPortout = 1'b0;
      BAout     = 1'b0;
      Rout      = 1'b0;
      PCin      = 1'b0;
      MARin     = 1'b0;
      MDRin     = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      Zin       = 1'b0;
      Rin       = 1'b0;
      CONin     = 1'b0;
      GRA       = 1'b0;
      GRB       = 1'b0;
      GRC       = 1'b0;
      IncPC     = 1'b0;
      Read      = 1'b0;
      Write     = 1'b0;
      operation = '0;
      Run       = (state != RESET_S) && (state != HALT_S);

      case (state)
         T0: begin
            if (!Stop) begin
               PCout = 1'b1;
               MARin = 1'b1;
               IncPC = 1'b1;
               PCin  = 1'b1;
            end
         end
         T1: begin
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         T3: begin
            if (is_mem_class(opcode)) begin
               GRB   = 1'b1;
               BAout = 1'b1;
               Yin   = 1'b1;
            end else if (is_rr_class(opcode) || is_imm_class(opcode)) begin
               GRB  = 1'b1;
               Rout = 1'b1;
               Yin  = 1'b1;
            end else if (opcode == OP_BR) begin
               GRA   = 1'b1;
               Rout  = 1'b1;
               CONin = 1'b1;
            end else if (opcode == OP_JR) begin
               GRA  = 1'b1;
               Rout = 1'b1;
               PCin = 1'b1;
            end
         end
         T4: begin
            if (is_mem_class(opcode)) begin
               Cout      = 1'b1;
               Zin       = 1'b1;
               operation = OPW'(ALU_ADD);
            end else if (is_rr_class(opcode)) begin
               GRC       = 1'b1;
               Rout      = 1'b1;
               Zin       = 1'b1;
               operation = OPW'(opcode);
            end else if (is_imm_class(opcode)) begin
               Cout      = 1'b1;
               Zin       = 1'b1;
               operation = OPW'(imm_alu_op(opcode));
            end else if (opcode == OP_BR) begin
               PCout = 1'b1;
               Yin   = 1'b1;
            end
         end
         T5: begin
            if ((opcode == OP_LD) || (opcode == OP_ST)) begin
               Zlowout = 1'b1;
               MARin   = 1'b1;
            end else if ((opcode == OP_LDI) || is_rr_class(opcode) ||
                         is_imm_class(opcode)) begin
               Zlowout = 1'b1;
               GRA     = 1'b1;
               Rin     = 1'b1;
            end else if (opcode == OP_BR) begin
               Cout      = 1'b1;
               Zin       = 1'b1;
               operation = OPW'(ALU_ADD);
            end
         end
         T6: begin
            if (opcode == OP_LD) begin
               Read  = 1'b1;
               MDRin = 1'b1;
            end else if (opcode == OP_ST) begin
               GRA   = 1'b1;
               Rout  = 1'b1;
               MDRin = 1'b1;
            end else if ((opcode == OP_BR) && CON_FF) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
            end
         end
         T7: begin
            if (opcode == OP_LD) begin
               MDRout = 1'b1;
               GRA    = 1'b1;
               Rin    = 1'b1;
            end else if (opcode == OP_ST) begin
               Write = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule
